// File: rtl/cell_max_sched_if.sv
// rtl/cell_max_sched_if.sv - pixel, engine and result signals of the cell maximum scheduler
interface cell_max_sched_if #(
  parameter int XW = 8,
  parameter int YW = 11
);
  logic          pix_valid;
  logic [23:0]   pix_data;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_ready;
  logic          eng_valid;
  logic [23:0]   eng_data;
  logic          eng_res_valid;
  logic [23:0]   eng_res;
  logic          res_valid;
  logic [23:0]   res_data;
  logic [XW-1:0] res_x;
  logic [YW-1:0] res_y;
  logic          res_ready;
  logic          ovf;

  modport master (
    input  pix_valid, pix_data, pix_sof, pix_eol, eng_res_valid, eng_res, res_ready,
    output pix_ready, eng_valid, eng_data, res_valid, res_data, res_x, res_y, ovf
  );

  modport slave (
    output pix_valid, pix_data, pix_sof, pix_eol, eng_res_valid, eng_res, res_ready,
    input  pix_ready, eng_valid, eng_data, res_valid, res_data, res_x, res_y, ovf
  );
endinterface

// File: rtl/cell_max_sched.sv
// rtl/cell_max_sched.sv - cell scheduler and tagged result FIFO for the per-cell RGB maximum engine
module cell_max_sched #(
  parameter int CELL_LEN   = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int XW         = 8,
  parameter int YW         = 11
) (
  input logic              clkn,
  input logic              resetn,
  cell_max_sched_if.master bus
);

  localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          EW       = 24 + XW + YW;
  localparam logic [7:0]  CELL_CNT = 8'(CELL_LEN);
  localparam logic [AW:0] F_FULL   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;
  state_t state_q, state_d;

  logic [7:0]    cnt_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [23:0]   last_q;
  logic          ready_q;
  logic          eng_valid_q;
  logic [23:0]   eng_data_q;
  logic          ovf_q;

  logic          sof_block, accept, take, beat, done;
  logic [7:0]    base_cnt, cnt_inc;
  logic [XW-1:0] base_x;
  logic [YW-1:0] base_y;

  // A sof arriving inside an open cell is held off until that cell is padded out.
  assign sof_block     = (state_q == RUN) && (cnt_q != 8'd0) && bus.pix_valid && bus.pix_sof;
  assign bus.pix_ready = ready_q && !sof_block;
  assign accept        = bus.pix_valid && bus.pix_ready;

  always_ff @(negedge clkn or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: begin
        if (sof_block || (take && bus.pix_eol && !done)) state_d = PAD;
        else if (take)                                   state_d = RUN;
      end
      PAD:     if (done) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    take     = accept && ((state_q == RUN) || bus.pix_sof);
    beat     = take || (state_q == PAD);
    base_cnt = (take && bus.pix_sof) ? 8'd0 : cnt_q;
    base_x   = (take && bus.pix_sof) ? '0 : x_q;
    base_y   = (take && bus.pix_sof) ? '0 : y_q;
    cnt_inc  = base_cnt + 8'd1;
    done     = beat && (cnt_inc == CELL_CNT);
  end

  always_ff @(negedge clkn or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      last_q      <= '0;
      ready_q     <= 1'b1;
      eng_valid_q <= 1'b0;
      eng_data_q  <= '0;
    end else begin
      ready_q     <= (state_d != PAD);
      eng_valid_q <= beat;
      if (take) begin
        last_q     <= bus.pix_data;
        eng_data_q <= bus.pix_data;
      end else if (beat) begin
        eng_data_q <= last_q;
      end
      if (beat) begin
        if (!done) begin
          cnt_q <= cnt_inc;
          x_q   <= base_x;
          y_q   <= base_y;
        end else if ((state_q == PAD) || bus.pix_eol) begin
          cnt_q <= '0;
          x_q   <= '0;
          y_q   <= base_y + 1'b1;
        end else begin
          cnt_q <= '0;
          x_q   <= base_x + 1'b1;
          y_q   <= base_y;
        end
      end
    end
  end

  logic [XW-1:0] tq_x [2];
  logic [YW-1:0] tq_y [2];
  logic          tq_wr, tq_rd, tag_pop, tag_in;
  logic [1:0]    tq_cnt;
  logic [EW-1:0] f_mem [FIFO_DEPTH];
  logic [AW-1:0] f_wr, f_rd;
  logic [AW:0]   f_cnt;
  logic          f_pop, f_push;

  assign tag_pop = bus.eng_res_valid && (tq_cnt != 2'd0);
  assign tag_in  = done && ((tq_cnt != 2'd2) || tag_pop);
  // The downstream pop is taken first, so a full FIFO can still accept this cycle.
  assign f_pop   = (f_cnt != '0) && bus.res_ready;
  assign f_push  = tag_pop && ((f_cnt != F_FULL) || f_pop);

  always_ff @(negedge clkn or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        tq_x[i] <= '0;
        tq_y[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) f_mem[i] <= '0;
      tq_wr  <= 1'b0;
      tq_rd  <= 1'b0;
      tq_cnt <= '0;
      f_wr   <= '0;
      f_rd   <= '0;
      f_cnt  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (tag_in) begin
        tq_x[tq_wr] <= base_x;
        tq_y[tq_wr] <= base_y;
        tq_wr       <= ~tq_wr;
      end
      if (tag_pop) tq_rd <= ~tq_rd;
      tq_cnt <= tq_cnt + {1'b0, tag_in} - {1'b0, tag_pop};
      if (f_push) begin
        f_mem[f_wr] <= {bus.eng_res, tq_x[tq_rd], tq_y[tq_rd]};
        f_wr        <= f_wr + 1'b1;
      end
      if (f_pop) f_rd <= f_rd + 1'b1;
      f_cnt <= f_cnt + {{AW{1'b0}}, f_push} - {{AW{1'b0}}, f_pop};
      if ((bus.eng_res_valid && !tag_pop) || (tag_pop && !f_push)) ovf_q <= 1'b1;
    end
  end

  assign bus.eng_valid = eng_valid_q;
  assign bus.eng_data  = eng_data_q;
  assign bus.res_valid = (f_cnt != '0);
  assign {bus.res_data, bus.res_x, bus.res_y} = f_mem[f_rd];
  assign bus.ovf       = ovf_q;

endmodule
